// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the UART transmit port: MMIO map, TX FSM states, status bit layout.
// No logic; constants and types only.
// No flow control of its own.
package uart_tx_port_pkg;

  localparam logic [31:0] ADDR_DATA = 32'hFFFF_FC80;
  localparam logic [31:0] ADDR_STAT = 32'hFFFF_FC84;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int STAT_IDLE  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;

endpackage

// File: rtl/uart_tx_port_sync_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; pop_dat shows the head entry combinationally.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push is refused when full unless a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: data/status registers, TX FIFO, serializer FSM.
// Latency: write to start bit 2 cycles when idle; status read data 1 cycle after rd.
// Backpressure: none on the bus; writes to a full FIFO are dropped and flagged in sticky ovf.
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] ADDR_DATA    = uart_tx_port_pkg::ADDR_DATA,
  parameter logic [31:0] ADDR_STAT    = uart_tx_port_pkg::ADDR_STAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        txd,
  output logic        tx_idle
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  tx_state_t   state;
  logic [7:0]  shreg;
  logic [2:0]  bitcnt;
  logic [BW-1:0] baud;
  logic        ovf;

  logic        wr_data;
  logic        rd_stat;
  logic        ovf_set;
  logic        pop;
  logic        full;
  logic        empty;
  logic [7:0]  pop_dat;
  logic        bit_end;
  logic [31:0] stat;
  logic        unused_din;

  assign unused_din = ^din[31:8];

  assign wr_data = wr && (addr == ADDR_DATA);
  assign rd_stat = rd && (addr == ADDR_STAT);
  assign bit_end = (baud == '0);
  // Pop when the serializer can take a byte: from IDLE, or on the last stop-bit cycle.
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign ovf_set = wr_data && full && !pop;
  assign tx_idle = empty && (state == IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_data),
    .push_dat (din[7:0]),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    stat             = '0;
    stat[STAT_OVF]   = ovf;
    stat[STAT_FULL]  = full;
    stat[STAT_EMPTY] = empty;
    stat[STAT_IDLE]  = tx_idle;
  end

  // An overflow in the same cycle as the clearing read must survive the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf  <= 1'b0;
      dout <= '0;
    end else begin
      dout <= rd_stat ? stat : 32'h0;
      ovf  <= rd_stat ? ovf_set : (ovf | ovf_set);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      txd    <= 1'b1;
      shreg  <= '0;
      bitcnt <= '0;
      baud   <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            state <= START;
            txd   <= 1'b0;
            shreg <= pop_dat;
            baud  <= BAUD_MAX;
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            bitcnt <= '0;
            baud   <= BAUD_MAX;
            txd    <= shreg[0];
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud   <= BAUD_MAX;
            shreg  <= {1'b0, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              txd <= shreg[1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              state <= START;
              txd   <= 1'b0;
              shreg <= pop_dat;
              baud  <= BAUD_MAX;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: directed scenarios plus random traffic against a queue/time-based line model.
module tb_uart_tx_port;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] A_DATA = 32'hFFFF_FC80;
  localparam logic [31:0] A_STAT = 32'hFFFF_FC84;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        wr   = 1'b0;
  logic        rd   = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din  = '0;
  logic [31:0] dout;
  logic        txd;
  logic        tx_idle;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .txd     (txd),
    .tx_idle (tx_idle)
  );

  // Reference model: a byte queue plus the start cycle of the frame on the line.
  logic [7:0]  m_q[$];
  logic [7:0]  m_byte  = '0;
  int          m_cyc   = 0;
  int          m_start = -1000;
  logic        m_ovf   = 1'b0;
  logic        m_txd   = 1'b1;
  logic        m_idle  = 1'b1;
  logic [31:0] m_dout  = '0;
  int          m_lim, m_k;
  logic        m_full, m_empty, m_cidle, m_pop, m_wd, m_rs, m_ovs;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_start = -1000;
      m_ovf   = 1'b0;
      m_txd   = 1'b1;
      m_idle  = 1'b1;
      m_dout  = '0;
    end else begin
      m_lim   = m_start + FRAME;
      m_full  = (m_q.size() == DEPTH);
      m_empty = (m_q.size() == 0);
      m_cidle = m_empty && (m_cyc >= m_lim);
      m_pop   = !m_empty && (m_cyc >= m_lim - 1);
      m_wd    = wr && (addr == A_DATA);
      m_rs    = rd && (addr == A_STAT);
      m_ovs   = m_wd && m_full && !m_pop;
      m_dout  = m_rs ? {28'b0, m_ovf, m_full, m_empty, m_cidle} : 32'h0;
      m_ovf   = m_rs ? m_ovs : (m_ovf | m_ovs);
      if (m_pop) begin
        m_byte  = m_q.pop_front();
        m_start = m_cyc + 1;
      end
      if (m_wd && (!m_full || m_pop)) m_q.push_back(din[7:0]);
      m_cyc = m_cyc + 1;
      m_lim = m_start + FRAME;
      if (m_cyc >= m_start && m_cyc < m_lim) begin
        m_k   = (m_cyc - m_start) / CPB;
        m_txd = (m_k == 0) ? 1'b0 : (m_k == 9) ? 1'b1 : m_byte[m_k-1];
      end else begin
        m_txd = 1'b1;
      end
      m_idle = (m_q.size() == 0) && (m_cyc >= m_lim);
    end
  end

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    wr = w; rd = r; addr = a; din = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({txd, tx_idle, dout} !== {1'b1, 1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_values txd/idle/dout got %b/%b/%h want 1/1/00000000", txd, tx_idle, dout);
    end
    rst = 1'b0;
    @(negedge clk);
    drive(0, 1, A_STAT, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0);
    n_cmp++;
    if (dout !== 32'h3) begin
      n_bad++;
      $display("FAIL reset_status got %h want 00000003", dout);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] pat;
    pat = 8'hA5;
    @(negedge clk);
    drive(1, 0, A_DATA, 32'h1234_56A5);
    for (int i = 1; i <= FRAME + 4; i++) begin
      @(negedge clk);
      if (i == 1) drive(0, 0, 32'h0, 32'h0);
      n_cmp++;
      if ({txd, tx_idle, dout} !== {m_txd, m_idle, m_dout}) begin
        n_bad++;
        $display("FAIL single_line cyc=%0d txd/idle/dout got %b/%b/%h want %b/%b/%h", m_cyc, txd, tx_idle, dout, m_txd, m_idle, m_dout);
      end
      if (i == 1) begin
        n_cmp++;
        if ({txd, tx_idle} !== 2'b10) begin
          n_bad++;
          $display("FAIL single_wr_plus1 txd/idle got %b/%b want 1/0", txd, tx_idle);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (txd !== 1'b0) begin
          n_bad++;
          $display("FAIL single_start_at_plus2 txd got %b want 0", txd);
        end
      end
      if (i >= 3 + CPB && i < 3 + 9 * CPB && ((i - 2) % CPB) == CPB / 2) begin
        n_cmp++;
        if (txd !== pat[(i - 2) / CPB - 1]) begin
          n_bad++;
          $display("FAIL single_bit%0d got %b want %b", (i - 2) / CPB - 1, txd, pat[(i - 2) / CPB - 1]);
        end
      end
      if (i == 2 + FRAME) begin
        n_cmp++;
        if ({txd, tx_idle} !== 2'b11) begin
          n_bad++;
          $display("FAIL single_idle_after_frame txd/idle got %b/%b want 1/1", txd, tx_idle);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int s1;
    logic prev;
    s1 = -1;
    prev = 1'b1;
    @(negedge clk);
    drive(1, 0, A_DATA, 32'h01);
    @(negedge clk);
    n_cmp++;
    if ({txd, tx_idle, dout} !== {m_txd, m_idle, m_dout}) begin
      n_bad++;
      $display("FAIL b2b_line cyc=%0d txd/idle/dout got %b/%b/%h want %b/%b/%h", m_cyc, txd, tx_idle, dout, m_txd, m_idle, m_dout);
    end
    drive(1, 0, A_DATA, 32'h80);
    for (int i = 2; i <= 2 * FRAME + 6; i++) begin
      @(negedge clk);
      drive(0, 0, 32'h0, 32'h0);
      n_cmp++;
      if ({txd, tx_idle, dout} !== {m_txd, m_idle, m_dout}) begin
        n_bad++;
        $display("FAIL b2b_line cyc=%0d txd/idle/dout got %b/%b/%h want %b/%b/%h", m_cyc, txd, tx_idle, dout, m_txd, m_idle, m_dout);
      end
      if (s1 < 0 && prev === 1'b1 && txd === 1'b0) s1 = i;
      if (s1 >= 0 && i == s1 + FRAME - 1) begin
        n_cmp++;
        if (txd !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_stop_bit got %b want 1", txd);
        end
      end
      if (s1 >= 0 && i == s1 + FRAME) begin
        n_cmp++;
        if (txd !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_second_start got %b want 0", txd);
        end
      end
      prev = txd;
    end
    n_cmp++;
    if (s1 != 2) begin
      n_bad++;
      $display("FAIL b2b_first_start offset got %0d want 2", s1);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({txd, tx_idle, dout} !== {m_txd, m_idle, m_dout}) begin
        n_bad++;
        $display("FAIL ovf_line cyc=%0d txd/idle/dout got %b/%b/%h want %b/%b/%h", m_cyc, txd, tx_idle, dout, m_txd, m_idle, m_dout);
      end
      drive(1, 0, A_DATA, 32'h10 + i);
    end
    @(negedge clk);
    drive(0, 1, A_STAT, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (dout !== 32'h8 && dout !== 32'hC) begin
      n_bad++;
      $display("FAIL ovf_status1 got %h want 00000008 or 0000000c", dout);
    end
    n_cmp++;
    if (dout !== m_dout) begin
      n_bad++;
      $display("FAIL ovf_status1_model got %h want %h", dout, m_dout);
    end
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0);
    n_cmp++;
    if (dout[3] !== 1'b0 || dout !== m_dout) begin
      n_bad++;
      $display("FAIL ovf_status2 got %h want %h with ovf 0", dout, m_dout);
    end
    for (int i = 0; i < 5 * FRAME + 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({txd, tx_idle, dout} !== {m_txd, m_idle, m_dout}) begin
        n_bad++;
        $display("FAIL ovf_drain cyc=%0d txd/idle/dout got %b/%b/%h want %b/%b/%h", m_cyc, txd, tx_idle, dout, m_txd, m_idle, m_dout);
      end
    end
    n_cmp++;
    if (tx_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_drained idle got %b want 1", tx_idle);
    end
  endtask

  task automatic test_pop_collision();
    bit found;
    found = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      @(negedge clk);
      drive(1, 0, A_DATA, 32'h20 + i);
    end
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      drive(0, 0, 32'h0, 32'h0);
      n_cmp++;
      if ({txd, tx_idle, dout} !== {m_txd, m_idle, m_dout}) begin
        n_bad++;
        $display("FAIL pop_wait cyc=%0d txd/idle/dout got %b/%b/%h want %b/%b/%h", m_cyc, txd, tx_idle, dout, m_txd, m_idle, m_dout);
      end
      if (m_cyc == m_start + FRAME - 1) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL pop_wait_timeout found %b want 1", found);
    end
    drive(1, 0, A_DATA, 32'h77);
    @(negedge clk);
    drive(0, 1, A_STAT, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0);
    n_cmp++;
    if (dout !== 32'h4) begin
      n_bad++;
      $display("FAIL pop_collision_status got %h want 00000004", dout);
    end
    for (int i = 0; i < 5 * FRAME + 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({txd, tx_idle, dout} !== {m_txd, m_idle, m_dout}) begin
        n_bad++;
        $display("FAIL pop_drain cyc=%0d txd/idle/dout got %b/%b/%h want %b/%b/%h", m_cyc, txd, tx_idle, dout, m_txd, m_idle, m_dout);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 0, A_DATA, (i == 0) ? 32'h00 : 32'h5A + i);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      drive(0, 0, 32'h0, 32'h0);
      if (m_cyc == m_start + 4 * CPB + 1) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found || txd !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_bit3 found/txd got %b/%b want 1/0", found, txd);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({txd, tx_idle} !== 2'b11) begin
      n_bad++;
      $display("FAIL rstmid_async txd/idle got %b/%b want 1/1", txd, tx_idle);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(0, 1, A_STAT, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0);
    n_cmp++;
    if (dout !== 32'h3) begin
      n_bad++;
      $display("FAIL rstmid_status got %h want 00000003", dout);
    end
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      n_cmp++;
      if (txd !== 1'b1 || {txd, tx_idle, dout} !== {m_txd, m_idle, m_dout}) begin
        n_bad++;
        $display("FAIL rstmid_quiet cyc=%0d txd/idle/dout got %b/%b/%h want 1/%b/%h", m_cyc, txd, tx_idle, dout, m_idle, m_dout);
      end
    end
  endtask

  task automatic test_bad_addr();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 4) begin
        n_cmp++;
        if (dout !== 32'h0 || txd !== 1'b1) begin
          n_bad++;
          $display("FAIL badaddr_quiet step=%0d dout/txd got %h/%b want 00000000/1", i, dout, txd);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (dout !== 32'h3) begin
          n_bad++;
          $display("FAIL badaddr_status got %h want 00000003", dout);
        end
      end
      if (i > 5) begin
        n_cmp++;
        if ({txd, tx_idle} !== 2'b11) begin
          n_bad++;
          $display("FAIL badaddr_no_frame txd/idle got %b/%b want 1/1", txd, tx_idle);
        end
      end
      case (i)
        0:       drive(0, 1, A_DATA, 32'h0);
        1:       drive(0, 1, 32'h0, 32'h0);
        2:       drive(1, 0, A_STAT, 32'hFF);
        4:       drive(0, 1, A_STAT, 32'h0);
        default: drive(0, 0, 32'h0, 32'h0);
      endcase
    end
  endtask

  task automatic test_random();
    logic        w, r;
    logic [31:0] a;
    bit          burst;
    for (int i = 0; i < 3000 + 5 * FRAME + 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({txd, tx_idle, dout} !== {m_txd, m_idle, m_dout}) begin
        n_bad++;
        $display("FAIL random_line cyc=%0d txd/idle/dout got %b/%b/%h want %b/%b/%h", m_cyc, txd, tx_idle, dout, m_txd, m_idle, m_dout);
      end
      if (i < 3000) begin
        burst = (i % 300) < 24;
        w = burst ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
        r = ($urandom_range(0, 7) == 0);
        a = ($urandom_range(0, 5) == 0) ? $urandom : (w ? A_DATA : A_STAT);
        drive(w, r, a, $urandom);
      end else begin
        drive(0, 0, 32'h0, 32'h0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_pop_collision();
    test_reset_mid_frame();
    test_bad_addr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped UART transmitter that lets the CPU send bytes out of the board, complementing the switch-input path. The CPU's store/load path writes bytes into a data register and polls a status register. Bytes are buffered in a small FIFO and serialized as 8N1 frames on `txd`. The block sits beside the data memory on the fast board clock `clk`. Integration logic turns each CPU store or load into a one-`clk` strobe and ORs `dout` into the memory read-data mux.

## Interface
- `CLKS_PER_BIT`, 868, `clk` cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, ≥ 2.
- `ADDR_DATA`, 32'hFFFF_FC80, write-only data register address.
- `ADDR_STAT`, 32'hFFFF_FC84, read-only status register address.

- `clk`  in  1  board clock; all logic on rising edge.
- `rst`  in  1  reset rst, asynchronous, active-high.
- `wr`  in  1  one-cycle write strobe.
- `rd`  in  1  one-cycle read strobe.
- `addr`  in  32  byte address, qualified by `wr`/`rd`.
- `din`  in  32  write data; only `din[7:0]` is used.
- `dout`  out  32  registered read data; 0 when not addressed.
- `txd`  out  1  serial line, idle high.
- `tx_idle`  out  1  FIFO empty and FSM in IDLE.

## Operation
- Write to the data register (`wr && addr==ADDR_DATA`):
  - FIFO not full: push `din[7:0]`.
  - FIFO full: byte dropped and sticky `ovf` set.
- `wr` to any other address: ignored.
- Read of the status register (`rd && addr==ADDR_STAT`):
  - Next cycle, `dout = {28'b0, ovf, full, empty, tx_idle}`.
  - `ovf` clears in the same cycle `dout` is loaded. If an overflow occurs in that same cycle, `ovf` stays 1.
- Any other cycle: `dout = 0`, so the OR-mux is safe.
- Read of the data register: returns 0.
- FIFO: `FIFO_DEPTH` entries, pointers one bit wider than the index, wrap modulo 2·`FIFO_DEPTH`.
  - `full` = MSBs differ and index bits equal.
  - `empty` = pointers equal.
- Simultaneous push and pop:
  - FIFO full: the pop frees a slot, the push is accepted, occupancy is unchanged, `ovf` is not set.
  - FIFO empty: push only; there is no bypass.
- TX FSM states and transitions:
  - IDLE: `txd=1`. If not empty, pop into `shreg` and go to START.
  - START: `txd=0` for `CLKS_PER_BIT` cycles, then DATA with `bitcnt=0`.
  - DATA: `txd=shreg[0]`. Each bit lasts `CLKS_PER_BIT` cycles. At each bit end, shift right and increment `bitcnt`. After bit 7, go to STOP. Bits go out LSB first.
  - STOP: `txd=1` for `CLKS_PER_BIT` cycles. At the end, if not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: loads `CLKS_PER_BIT-1` on each state or bit entry, decrements, and the bit ends at 0. Width is `$clog2(CLKS_PER_BIT)`.
- `txd` is driven from a flop; no combinational path to the pin.

## Timing
- Reset values:
  - `txd=1`, `dout=0`, `tx_idle=1`.
  - FIFO empty with both pointers 0, `ovf=0`, FSM in IDLE, counters 0.
- Reset asserted mid-frame:
  - `txd` goes to 1 asynchronously and the frame is aborted.
  - FIFO contents are discarded.
- Write-to-line latency, when idle with an empty FIFO:
  - Cycle N: `wr` strobe.
  - Cycle N+1: FIFO non-empty, FSM still IDLE.
  - Cycle N+2: FSM in START, `txd=0`.
- Frame length: exactly 10·`CLKS_PER_BIT` cycles from the first `txd=0` to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle after the previous stop bit's last cycle.
- `tx_idle` rises on the cycle the FSM enters IDLE with an empty FIFO.
- Status read latency: 1 cycle.
- `rd` and `wr` on the same cycle are both serviced.

## Structure
- Shared package holds:
  - the address constants `ADDR_DATA`/`ADDR_STAT` (the MMIO map used by the data memory decode);
  - the state enum `{IDLE, START, DATA, STOP}`;
  - the status bit indices.
- One sub-module: `sync_fifo` (parameterised width/depth; push/pop/full/empty). It is reusable for a future receiver.
- Top-level `uart_tx_port` holds the decode, status register, and TX FSM.

## Test plan
All scenarios use `CLKS_PER_BIT=4` and `FIFO_DEPTH=4`.
1. After reset, write 8'hA5:
   - `txd` goes low at write cycle + 2.
   - Sampled bits 1,0,1,0,0,1,0,1 then a high stop bit, 4 cycles each.
   - `tx_idle` is 1 again 40 cycles after the start bit.
2. Write 8'h01, 8'h80 on consecutive strobes:
   - Two frames with no gap; the second start bit begins exactly 40 cycles after the first.
3. Write 6 bytes 8'h10–8'h15 while the line is busy:
   - Bytes 8'h10–8'h14 are transmitted in order (one is in the shifter, four are queued).
   - 8'h15 is dropped.
   - Status read returns 32'h8 (`ovf=1`, `full=0`, `empty=0`, `tx_idle=0`) or 32'hC when read while full.
   - A second read shows `ovf=0`.
4. Fill the FIFO, then write on the exact cycle the FSM pops:
   - The byte is accepted and `ovf` stays 0.
5. Assert `rst` during bit 3 of a frame:
   - `txd=1` immediately, status reads 32'h3.
   - No further frames are sent.
6. Issue `rd` at ADDR_DATA, `rd` at 32'h0, and `wr` at ADDR_STAT:
   - `dout` stays 0 and the FIFO is unchanged.
